// File: rtl/fatori_err_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : fatori_err_aggregator
// Description : Turns voter mismatch levels into event pulses and schedules
//               scrubs of registers with correctable disagreements.
// Revision    : 1.0 - initial release
// ============================================================================
module fatori_err_aggregator #(
    parameter int NUM_REGS    = 16,
    parameter int SCRUB_DELAY = 4,
    parameter int ACK_TIMEOUT = 32,
    parameter int CNT_W       = 8,
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [NUM_REGS-1:0] min_err_i,
    input  logic [NUM_REGS-1:0] maj_err_i,
    input  logic                scrub_ack_i,
    output logic                new_min_err_o,
    output logic                new_maj_err_o,
    output logic                scrub_occurred_o,
    output logic                scrub_req_o,
    output logic [IDX_W-1:0]    scrub_idx_o,
    output logic [NUM_REGS-1:0] pending_o,
    output logic [CNT_W-1:0]    min_evt_cnt_o,
    output logic [CNT_W-1:0]    maj_evt_cnt_o
);

    localparam int TMR_W = (SCRUB_DELAY > 0) ? $clog2(SCRUB_DELAY + 1) : 1;
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SCRUB_DELAY);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_REQ   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_REGS-1:0] min_q, maj_q, pending_q, pending_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                new_min_q, new_min_d;
    logic                new_maj_q, new_maj_d;
    logic                occ_q, occ_d;
    logic [CNT_W-1:0]    min_cnt_q, min_cnt_d;
    logic [CNT_W-1:0]    maj_cnt_q, maj_cnt_d;

    logic [NUM_REGS-1:0] rise_min, rise_maj, cand, sel_oh, sel_clr;
    logic [IDX_W-1:0]    pick;
    logic                abort, timeout_esc;

    always_comb begin
        rise_min = min_err_i & ~min_q & ~maj_err_i;
        rise_maj = maj_err_i & ~maj_q;
        // Bits already in major error are not worth scrubbing
        cand     = pending_q & ~maj_err_i;
        sel_oh   = NUM_REGS'(1) << idx_q;
        abort    = maj_err_i[idx_q];
        pick     = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (cand[i]) pick = IDX_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        to_d        = to_q;
        sel_clr     = '0;
        occ_d       = 1'b0;
        timeout_esc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i && (cand != '0)) begin
                    idx_d   = pick;
                    timer_d = TMR_LOAD;
                    to_d    = '0;
                    state_d = (SCRUB_DELAY == 0) ? S_REQ : S_DELAY;
                end
            end
            S_DELAY: begin
                if (abort) begin
                    sel_clr = sel_oh;
                    state_d = S_IDLE;
                end else if (timer_q <= TMR_W'(1)) begin
                    state_d = S_REQ;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_REQ: begin
                // Ack wins over a timeout expiring in the same cycle
                if (abort) begin
                    sel_clr = sel_oh;
                    state_d = S_IDLE;
                end else if (scrub_ack_i) begin
                    sel_clr = sel_oh;
                    occ_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (to_q == TO_LAST) begin
                    sel_clr     = sel_oh;
                    timeout_esc = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pending_d = (pending_q | (enable_i ? rise_min : '0)) & ~(maj_err_i | sel_clr);
        new_min_d = enable_i & (|rise_min);
        new_maj_d = (enable_i & (|rise_maj)) | timeout_esc;
        min_cnt_d = min_cnt_q;
        maj_cnt_d = maj_cnt_q;
        if (new_min_d && (min_cnt_q != CNT_MAX)) min_cnt_d = min_cnt_q + 1'b1;
        if (new_maj_d && (maj_cnt_q != CNT_MAX)) maj_cnt_d = maj_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            min_q     <= '0;
            maj_q     <= '0;
            pending_q <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            to_q      <= '0;
            new_min_q <= 1'b0;
            new_maj_q <= 1'b0;
            occ_q     <= 1'b0;
            min_cnt_q <= '0;
            maj_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_err_i;
            maj_q     <= maj_err_i;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            to_q      <= to_d;
            new_min_q <= new_min_d;
            new_maj_q <= new_maj_d;
            occ_q     <= occ_d;
            min_cnt_q <= min_cnt_d;
            maj_cnt_q <= maj_cnt_d;
        end
    end

    assign new_min_err_o    = new_min_q;
    assign new_maj_err_o    = new_maj_q;
    assign scrub_occurred_o = occ_q;
    assign scrub_req_o      = (state_q == S_REQ);
    assign scrub_idx_o      = idx_q;
    assign pending_o        = pending_q;
    assign min_evt_cnt_o    = min_cnt_q;
    assign maj_evt_cnt_o    = maj_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fatori_err_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fatori_err_aggregator
// Description : Self-checking bench: vector table, directed sequences and
//               randomized traffic against a timestamp-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fatori_err_aggregator;

    localparam int NR = 16;
    localparam int SD = 4;
    localparam int AT = 32;
    localparam int CW = 2;
    localparam int IW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, en, ack;
    logic [NR-1:0] min_i, maj_i;
    logic          new_min, new_maj, occ, req;
    logic [IW-1:0] idx;
    logic [NR-1:0] pend;
    logic [CW-1:0] min_cnt, maj_cnt;

    fatori_err_aggregator #(
        .NUM_REGS(NR), .SCRUB_DELAY(SD), .ACK_TIMEOUT(AT), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en),
        .min_err_i(min_i), .maj_err_i(maj_i), .scrub_ack_i(ack),
        .new_min_err_o(new_min), .new_maj_err_o(new_maj),
        .scrub_occurred_o(occ), .scrub_req_o(req), .scrub_idx_o(idx),
        .pending_o(pend), .min_evt_cnt_o(min_cnt), .maj_evt_cnt_o(maj_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a scrub is a timestamped job; its phase follows from age
    logic [NR-1:0] m_pmin, m_pmaj, m_pend;
    bit            m_busy, m_nmin, m_nmaj, m_occ, m_req;
    int            m_sel, m_minc, m_majc;
    longint        m_cyc, m_t0;

    function automatic void model_step();
        logic [NR-1:0] rmin, rmaj, clr, cnd;
        bit            tout, done;
        longint        age;
        m_cyc++;
        if (rst) begin
            m_pmin = '0; m_pmaj = '0; m_pend = '0; m_busy = 0; m_sel = 0;
            m_nmin = 0; m_nmaj = 0; m_occ = 0; m_req = 0; m_minc = 0; m_majc = 0;
            return;
        end
        rmin = min_i & ~m_pmin & ~maj_i;
        rmaj = maj_i & ~m_pmaj;
        clr  = '0; tout = 0; done = 0;
        cnd  = m_pend & ~maj_i;
        if (m_busy) begin
            age = m_cyc - m_t0;
            if (age >= 1 && maj_i[m_sel]) begin
                m_busy = 0; clr[m_sel] = 1'b1;
            end else if (age >= SD + 1 && ack) begin
                m_busy = 0; clr[m_sel] = 1'b1; done = 1;
            end else if (age == SD + AT) begin
                m_busy = 0; clr[m_sel] = 1'b1; tout = 1;
            end
        end else if (en && cnd != '0) begin
            for (int i = NR - 1; i >= 0; i--) if (cnd[i]) m_sel = i;
            m_busy = 1;
            m_t0   = m_cyc;
        end
        m_pend = (m_pend | (en ? rmin : '0)) & ~maj_i & ~clr;
        m_nmin = en && (rmin != '0);
        m_nmaj = (en && (rmaj != '0)) || tout;
        m_occ  = done;
        m_req  = m_busy && (m_cyc - m_t0 >= SD);
        if (m_nmin && m_minc < CMAX) m_minc++;
        if (m_nmaj && m_majc < CMAX) m_majc++;
        m_pmin = min_i;
        m_pmaj = maj_i;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [39:0] g, e;
        g = {new_min, new_maj, occ, req, idx, pend, min_cnt, maj_cnt};
        e = {m_nmin, m_nmaj, m_occ, m_req, m_sel[IW-1:0], m_pend, m_minc[CW-1:0], m_majc[CW-1:0]};
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL model cyc=%0d: got {nmin,nmaj,occ,req,idx,pend,minc,majc}=%h expected %h",
                     m_cyc, g, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; ack = 1'b0; min_i = '0; maj_i = '0;
        tick();
        check("reset_outputs", {new_min, new_maj, occ, req, idx, pend, min_cnt, maj_cnt}, 0);
        rst = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!req && n < 60) begin
            tick();
            n++;
        end
        if (!req) check(name, 0, 1);
    endtask

    typedef struct packed {
        logic [NR-1:0] min;
        logic [NR-1:0] maj;
        logic          en;
        logic          exp_nmin;
        logic          exp_nmaj;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    initial begin
        vec_t tbl [15];
        int   cnt_exp [5];
        int   c1, c2;

        tbl[0]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{16'h0008, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd1};
        tbl[2]  = '{16'h0008, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd1};
        tbl[3]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd1};
        tbl[4]  = '{16'h0008, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd2};
        tbl[5]  = '{16'h0024, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd3};
        tbl[6]  = '{16'h0024, 16'h0002, 1'b1, 1'b0, 1'b1, 2'd3};
        tbl[7]  = '{16'h0026, 16'h0002, 1'b1, 1'b0, 1'b0, 2'd3};
        tbl[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd3};
        tbl[9]  = '{16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd3};
        tbl[10] = '{16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd3};
        tbl[11] = '{16'h0300, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd3};
        tbl[12] = '{16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 2'd3};
        tbl[13] = '{16'h0000, 16'h8000, 1'b1, 1'b0, 1'b0, 2'd3};
        tbl[14] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd3};
        cnt_exp = '{1, 2, 3, 3, 3};

        m_cyc = 0; m_t0 = 0;
        rst = 1'b1; en = 1'b1; ack = 1'b0; min_i = '0; maj_i = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // Vector table: pulse generation, enable gating, saturation
        for (int i = 0; i < 15; i++) begin
            min_i = tbl[i].min; maj_i = tbl[i].maj; en = tbl[i].en;
            tick();
            check($sformatf("tbl%0d_nmin", i), new_min, tbl[i].exp_nmin);
            check($sformatf("tbl%0d_nmaj", i), new_maj, tbl[i].exp_nmaj);
            check($sformatf("tbl%0d_cnt", i), min_cnt, tbl[i].exp_cnt);
        end

        // Single minor error, full scrub with delay then ack
        do_reset();
        min_i = 16'h0008;
        tick();
        check("A_pulse", new_min, 1);
        check("A_pend", pend, 16'h0008);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("A_req_%0d", i), req, (i == 5));
        end
        check("A_idx", idx, 3);
        ack = 1'b1; tick(); ack = 1'b0;
        check("A_occ", occ, 1);
        check("A_pend_clr", pend, 0);
        check("A_req_drop", req, 0);
        check("A_cnt", min_cnt, 1);
        tick();
        check("A_occ_once", occ, 0);

        // Two bits at once, serviced lowest first
        do_reset();
        min_i = 16'h0024;
        tick();
        check("B_pulse", new_min, 1);
        check("B_pend", pend, 16'h0024);
        wait_req("B_wait1");
        check("B_idx1", idx, 2);
        ack = 1'b1; tick(); ack = 1'b0;
        check("B_occ1", occ, 1);
        check("B_pend1", pend, 16'h0020);
        wait_req("B_wait2");
        check("B_idx2", idx, 5);
        ack = 1'b1; tick(); ack = 1'b0;
        check("B_occ2", occ, 1);
        check("B_pend2", pend, 0);
        check("B_cnt", min_cnt, 1);

        // Unacknowledged request escalates once
        do_reset();
        min_i = 16'h0001;
        tick();
        wait_req("C_wait");
        check("C_idx", idx, 0);
        c1 = 1; c2 = 0;
        repeat (40) begin
            tick();
            if (req) c1++;
            if (new_maj) c2++;
        end
        check("C_req_cycles", c1, AT);
        check("C_maj_pulses", c2, 1);
        check("C_maj_cnt", maj_cnt, 1);
        check("C_pend", pend, 0);
        check("C_req", req, 0);

        // Major error on the scrubbed bit aborts the request
        do_reset();
        min_i = 16'h0080;
        tick();
        wait_req("D_wait");
        check("D_idx", idx, 7);
        maj_i = 16'h0080;
        tick();
        check("D_maj_pulse", new_maj, 1);
        check("D_req_drop", req, 0);
        check("D_pend", pend, 0);
        c1 = 0; c2 = 0;
        repeat (40) begin
            tick();
            if (occ) c1++;
            if (new_maj) c2++;
        end
        check("D_no_occ", c1, 0);
        check("D_no_esc", c2, 0);
        check("D_maj_cnt", maj_cnt, 1);

        // Both flags on one bit count only as major
        do_reset();
        min_i = 16'h0002; maj_i = 16'h0002;
        tick();
        check("E_maj", new_maj, 1);
        check("E_min", new_min, 0);
        check("E_pend", pend, 0);
        tick();
        check("E_pend_hold", pend, 0);

        // Counter saturation over five edges
        do_reset();
        for (int i = 0; i < 5; i++) begin
            min_i = 16'h0001; tick();
            check($sformatf("F_cnt_%0d", i), min_cnt, cnt_exp[i]);
            min_i = 16'h0000; tick();
        end

        // Reset while delaying
        do_reset();
        min_i = 16'h0010;
        tick();
        tick();
        check("G_in_delay", req, 0);
        rst = 1'b1; min_i = '0;
        tick();
        check("G_reset", {new_min, new_maj, occ, req, idx, pend, min_cnt, maj_cnt}, 0);
        rst = 1'b0;
        repeat (SD + 2) tick();
        check("G_no_req", req, 0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            en  = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 3) == 0) min_i[$urandom_range(0, NR - 1)] ^= 1'b1;
            if ($urandom_range(0, 24) == 0) maj_i[$urandom_range(0, NR - 1)] ^= 1'b1;
            ack = (n < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 59) == 0);
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fatori_err_aggregator.md
Name: fatori_err_aggregator

Overview:
- Sits directly upstream of the fault manager.
- Collects per-register mismatch flags from the M-of-N voters and converts them into single-cycle event pulses: new minor error, new major error, and scrub occurred.
- Runs a scrub scheduler that asks the voters to rewrite the replicas of any register that saw a correctable (minor) disagreement.
- Escalates to a major event when a scrub request goes unacknowledged.

Parameters:
NUM_REGS, 16, number of voted registers monitored (1..64)
SCRUB_DELAY, 4, cycles between picking a pending register and raising its scrub request (0 allowed)
ACK_TIMEOUT, 32, cycles scrub_req_o may wait for scrub_ack_i before escalation (>=1)
CNT_W, 8, width of the saturating event counters

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, synchronous, active-high
enable_i  input  1  aggregation enable; 0 suppresses new pulses and new scrub starts
min_err_i  input  NUM_REGS  per-register level: one replica disagrees, majority valid
maj_err_i  input  NUM_REGS  per-register level: no majority
scrub_ack_i  input  1  voter has rewritten replicas of scrub_idx_o
new_min_err_o  output  1  one-cycle pulse, feeds agg_mon_new_min_err
new_maj_err_o  output  1  one-cycle pulse, feeds agg_mon_new_maj_err
scrub_occurred_o  output  1  one-cycle pulse, feeds agg_mon_scrub_occurred
scrub_req_o  output  1  scrub request level
scrub_idx_o  output  $clog2(NUM_REGS) (min 1)  index of register being scrubbed
pending_o  output  NUM_REGS  registers awaiting scrub
min_evt_cnt_o  output  CNT_W  saturating count of cycles with new_min_err_o
maj_evt_cnt_o  output  CNT_W  saturating count of cycles with new_maj_err_o

Behaviour:
- Reset (rst_i=1 at clk edge):
  - All outputs 0.
  - Edge-history registers min_q and maj_q = 0, FSM = IDLE, timers = 0.
  - Reset mid-scrub drops the request in the next cycle with no scrub_occurred_o.
- Edge detection, registered inputs, 1-cycle latency:
  - rise_min = min_err_i & ~min_q & ~maj_err_i.
  - rise_maj = maj_err_i & ~maj_q.
  - A bit with both flags counts only as major.
  - Pulses appear the cycle after the input edge is sampled.
- new_min_err_o = enable_i & |rise_min. new_maj_err_o = (enable_i & |rise_maj) | timeout_esc.
  - Multiple bits rising in one cycle produce one pulse.
  - A bit held high does not re-pulse. Deassert then reassert pulses again.
- pending:
  - Set on rise_min while enabled.
  - Cleared on scrub ack, on timeout, or when maj_err_i is high for that bit; the clear for a major bit takes priority over a simultaneous set.
  - A set on an already-pending bit is a no-op.
- Scrub FSM:
  - IDLE: if enable_i and pending != 0, latch the lowest-index pending bit into scrub_idx_o and load the delay timer with SCRUB_DELAY. Go to DELAY, or directly to REQ if SCRUB_DELAY=0.
  - DELAY: decrement timer; at 0 go to REQ.
  - REQ: scrub_req_o=1 and timeout counter runs.
    - On scrub_ack_i: clear pending[idx], pulse scrub_occurred_o next cycle, go to IDLE.
    - If ACK_TIMEOUT cycles elapse without ack: timeout_esc pulses new_maj_err_o once, clear pending[idx], go to IDLE.
  - Abort: in DELAY or REQ, if maj_err_i[idx] is high, drop the request, clear pending, go to IDLE. No scrub_occurred_o and no timeout escalation.
  - scrub_ack_i outside REQ is ignored.
  - Ack in the same cycle as timeout expiry counts as an ack (no escalation).
  - IDLE takes at least one cycle between consecutive scrubs.
- enable_i=0:
  - Suppresses input-derived pulses and new pending sets.
  - An in-progress scrub completes, and its timeout escalation still fires.
  - Edge history keeps updating, so re-enabling does not generate stale pulses.
- Counters increment by 1 per pulse cycle and saturate at 2^CNT_W-1; no wrap.
- scrub_idx_o holds its last value when idle.

Test Plan:
- min_err_i[3] rises and stays high, SCRUB_DELAY=4 -> new_min_err_o pulse 1 cycle later, pending_o=0x0008, scrub_req_o with idx=3 after 4 delay cycles; ack -> scrub_occurred_o pulse, pending_o=0, min_evt_cnt_o=1.
- min_err_i bits 5 and 2 rise in the same cycle -> single new_min_err_o pulse, scrubs serviced idx 2 then idx 5, two scrub_occurred_o pulses.
- Request on idx 0 with no ack for ACK_TIMEOUT=32 cycles -> exactly one new_maj_err_o pulse, maj_evt_cnt_o=1, pending cleared, scrub_req_o=0.
- During REQ on idx 7, maj_err_i[7] rises -> new_maj_err_o pulse, request dropped next cycle, no scrub_occurred_o, no timeout pulse.
- min_err_i and maj_err_i both rise on bit 1 -> only new_maj_err_o pulses; pending_o[1] stays 0.
- CNT_W=2, five separate minor edges -> min_evt_cnt_o reads 1, 2, 3, 3, 3. Assert rst_i during DELAY -> all outputs 0 next cycle.
